mem_arbiter: RTL and testbench

- Sits directly below the instruction and data caches of the pipelined MIPS core.
- Services their miss requests; these misses are what drive hitF/hitM low and stall the pipeline.
- Arbitrates between the two caches and drives one shared word-wide main-memory port.
- For D-cache misses on a dirty line, it writes the victim block back before refilling.

---
 rtl/mem_pkg.sv | 19 +
 rtl/mem_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_arbiter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and defaults for the cache-miss memory arbiter
package mem_pkg;

    localparam int DEF_BLOCK_WORDS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } stateT;

    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_I    = 2'b01,
        GNT_D    = 2'b10
    } gntT;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fixed-priority I/D cache miss arbiter driving one word-wide memory port
import mem_pkg::*;

module mem_arbiter #(
    parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
    parameter int WIDX_W      = $clog2(BLOCK_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_req,
    input  logic [31:0]       ic_addr,
    input  logic              dc_req,
    input  logic [31:0]       dc_addr,
    input  logic              dc_dirty,
    input  logic [31:0]       dc_wb_addr,
    input  logic [31:0]       dc_wdata,
    output logic [WIDX_W-1:0] fill_widx,
    output logic [31:0]       fill_data,
    output logic              ic_rvalid,
    output logic              dc_rvalid,
    output logic              ic_done,
    output logic              dc_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    localparam logic [WIDX_W-1:0] LAST_WIDX = WIDX_W'(BLOCK_WORDS - 1);

    stateT             state, stateNext;
    gntT               gnt, gntNext;
    logic [WIDX_W-1:0] cnt, cntNext;

    // Word address is the block base with the counter spliced into the word-index field.
    logic [31:0] icWordAddr, dcWordAddr, wbWordAddr;
    assign icWordAddr = {ic_addr[31:WIDX_W+2], cnt, 2'b00};
    assign dcWordAddr = {dc_addr[31:WIDX_W+2], cnt, 2'b00};
    assign wbWordAddr = {dc_wb_addr[31:WIDX_W+2], cnt, 2'b00};

    logic unusedAddrLowBits;
    assign unusedAddrLowBits = ^{ic_addr[WIDX_W+1:0], dc_addr[WIDX_W+1:0], dc_wb_addr[WIDX_W+1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= GNT_NONE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            gnt   <= gntNext;
            cnt   <= cntNext;
        end
    end

    always_comb begin
        stateNext = state;
        gntNext   = gnt;
        cntNext   = cnt;
        case (state)
            IDLE: begin
                cntNext = '0;
                if (dc_req) begin
                    gntNext   = GNT_D;
                    stateNext = dc_dirty ? WB : FILL;
                end else if (ic_req) begin
                    gntNext   = GNT_I;
                    stateNext = FILL;
                end
            end
            WB: begin
                if (mem_ack) begin
                    cntNext = cnt + WIDX_W'(1);
                    if (cnt == LAST_WIDX) stateNext = FILL;
                end
            end
            FILL: begin
                if (mem_ack) begin
                    cntNext = cnt + WIDX_W'(1);
                    if (cnt == LAST_WIDX) stateNext = DONE;
                end
            end
            DONE: begin
                stateNext = IDLE;
                gntNext   = GNT_NONE;
            end
            default: begin
                stateNext = IDLE;
                gntNext   = GNT_NONE;
                cntNext   = '0;
            end
        endcase
    end

    // Outputs decode only registered state, so an asynchronous reset zeroes them at once.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        fill_data = '0;
        ic_rvalid = 1'b0;
        dc_rvalid = 1'b0;
        ic_done   = 1'b0;
        dc_done   = 1'b0;
        case (state)
            WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = wbWordAddr;
                mem_wdata = dc_wdata;
            end
            FILL: begin
                mem_req  = 1'b1;
                mem_addr = (gnt == GNT_D) ? dcWordAddr : icWordAddr;
                if (mem_ack) begin
                    fill_data = mem_rdata;
                    ic_rvalid = (gnt == GNT_I);
                    dc_rvalid = (gnt == GNT_D);
                end
            end
            DONE: begin
                ic_done = (gnt == GNT_I);
                dc_done = (gnt == GNT_D);
            end
            default: ;
        endcase
    end

    assign fill_widx = cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - table-driven and sequence checks for mem_arbiter
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        icReq, dcReq, dcDirty, memAck;
    logic [31:0] icAddr, dcAddr, dcWbAddr, dcWdata, memRdata;
    logic [1:0]  fillWidx;
    logic [31:0] fillData, memAddr, memWdata;
    logic        icRvalid, dcRvalid, icDone, dcDone, memReq, memWe;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Memory model returns the low address half tagged with BEEF; the victim source tags by word index.
    assign memRdata = {memAddr[15:0], 16'hBEEF};
    assign dcWdata  = 32'hD000_0000 | 32'(fillWidx);

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .ic_req(icReq), .ic_addr(icAddr),
        .dc_req(dcReq), .dc_addr(dcAddr), .dc_dirty(dcDirty),
        .dc_wb_addr(dcWbAddr), .dc_wdata(dcWdata),
        .fill_widx(fillWidx), .fill_data(fillData),
        .ic_rvalid(icRvalid), .dc_rvalid(dcRvalid),
        .ic_done(icDone), .dc_done(dcDone),
        .mem_req(memReq), .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata),
        .mem_ack(memAck), .mem_rdata(memRdata)
    );

    typedef struct {
        logic        ic, dc, dirty, ack;
        logic        eReq, eWe;
        logic [31:0] eAddr, eWdata;
        logic [1:0]  eWidx;
        logic        eIcV, eDcV, eIcD, eDcD;
    } vecT;

    vecT tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chkAllZero(input string tag);
        chk({tag, " mem_req"}, 32'(memReq), 0);
        chk({tag, " mem_we"}, 32'(memWe), 0);
        chk({tag, " mem_addr"}, memAddr, 0);
        chk({tag, " mem_wdata"}, memWdata, 0);
        chk({tag, " fill_widx"}, 32'(fillWidx), 0);
        chk({tag, " fill_data"}, fillData, 0);
        chk({tag, " rvalids"}, {30'd0, icRvalid, dcRvalid}, 0);
        chk({tag, " dones"}, {30'd0, icDone, dcDone}, 0);
    endtask

    function automatic vecT mk(input logic ic, dc, dr, rq, we, input logic [31:0] ad, wd,
                               input logic [1:0] wx, input logic iv, dv, id, dd);
        vecT v;
        v.ic = ic; v.dc = dc; v.dirty = dr; v.ack = 1'b1;
        v.eReq = rq; v.eWe = we; v.eAddr = ad; v.eWdata = wd; v.eWidx = wx;
        v.eIcV = iv; v.eDcV = dv; v.eIcD = id; v.eDcD = dd;
        return v;
    endfunction

    task automatic idleRow(input logic ic, dc, dr);
        tbl.push_back(mk(ic, dc, dr, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0));
    endtask

    task automatic fillRows(input logic ic, dc, input logic [31:0] base, input logic isD);
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(ic, dc, 0, 1, 0, base + 32'(4 * i), 0, 2'(i), !isD, isD, 0, 0));
    endtask

    task automatic wbRows(input logic ic, dc);
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(ic, dc, 1, 1, 1, 32'h8000_0040 + 32'(4 * i), 32'hD000_0000 + 32'(i),
                             2'(i), 0, 0, 0, 0));
    endtask

    task automatic doneRow(input logic ic, dc, isD);
        tbl.push_back(mk(ic, dc, 0, 0, 0, 0, 0, 2'd0, 0, 0, !isD, isD));
    endtask

    initial begin
        int nV, stableBad, doneCnt, doneAt, firstFillWidx;
        logic doneSeen, prevPending;
        logic [31:0] prevAddr, prevWd, firstFillAddr;

        rst = 1'b1; icReq = 1'b1; dcReq = 1'b1; dcDirty = 1'b1; memAck = 1'b1;
        icAddr = 32'h0000_1234; dcAddr = 32'h0000_2000; dcWbAddr = 32'h8000_0040;
        repeat (3) @(negedge clk);
        #1 chkAllZero("reset");
        @(negedge clk);
        icReq = 1'b0; dcReq = 1'b0; dcDirty = 1'b0; rst = 1'b0;

        idleRow(1, 0, 0); fillRows(1, 0, 32'h1230, 0); doneRow(1, 0, 0); idleRow(0, 0, 0);
        idleRow(0, 1, 1); wbRows(0, 1); fillRows(0, 1, 32'h2000, 1); doneRow(0, 1, 1); idleRow(0, 0, 0);
        idleRow(1, 1, 0); fillRows(1, 1, 32'h2000, 1); doneRow(1, 1, 1);
        idleRow(1, 0, 0); fillRows(1, 0, 32'h1230, 0); doneRow(1, 0, 0);
        idleRow(1, 0, 0); fillRows(1, 0, 32'h1230, 0); doneRow(1, 0, 0);
        idleRow(0, 0, 0);

        foreach (tbl[r]) begin
            @(negedge clk);
            icReq = tbl[r].ic; dcReq = tbl[r].dc; dcDirty = tbl[r].dirty; memAck = tbl[r].ack;
            #1;
            chk($sformatf("row%0d mem_req", r), 32'(memReq), 32'(tbl[r].eReq));
            chk($sformatf("row%0d fill_widx", r), 32'(fillWidx), 32'(tbl[r].eWidx));
            chk($sformatf("row%0d ic_rvalid", r), 32'(icRvalid), 32'(tbl[r].eIcV));
            chk($sformatf("row%0d dc_rvalid", r), 32'(dcRvalid), 32'(tbl[r].eDcV));
            chk($sformatf("row%0d ic_done", r), 32'(icDone), 32'(tbl[r].eIcD));
            chk($sformatf("row%0d dc_done", r), 32'(dcDone), 32'(tbl[r].eDcD));
            if (tbl[r].eReq) begin
                chk($sformatf("row%0d mem_we", r), 32'(memWe), 32'(tbl[r].eWe));
                chk($sformatf("row%0d mem_addr", r), memAddr, tbl[r].eAddr);
                if (tbl[r].eWe) chk($sformatf("row%0d mem_wdata", r), memWdata, tbl[r].eWdata);
            end
            if (tbl[r].eIcV || tbl[r].eDcV)
                chk($sformatf("row%0d fill_data", r), fillData, {tbl[r].eAddr[15:0], 16'hBEEF});
        end

        // Dirty D-miss with an ack only every third cycle.
        nV = 0; stableBad = 0; doneSeen = 1'b0; prevPending = 1'b0; prevAddr = '0; prevWd = '0;
        dcReq = 1'b1; dcDirty = 1'b1;
        for (int cyc = 0; cyc < 80 && !doneSeen; cyc++) begin
            @(negedge clk);
            memAck = (cyc % 3 == 2);
            #1;
            if (memReq && prevPending && (memAddr !== prevAddr || memWdata !== prevWd)) stableBad++;
            if (dcRvalid) begin
                chk($sformatf("wait rd%0d addr", nV), memAddr, 32'h2000 + 32'(4 * nV));
                chk($sformatf("wait rd%0d data", nV), fillData, {16'h2000 + 16'(4 * nV), 16'hBEEF});
                nV++;
            end
            if (dcDone) begin doneSeen = 1'b1; dcReq = 1'b0; dcDirty = 1'b0; end
            prevPending = memReq && !memAck;
            prevAddr = memAddr; prevWd = memWdata;
        end
        chk("wait done seen", 32'(doneSeen), 1);
        chk("wait rvalid count", 32'(nV), 4);
        chk("wait addr/wdata stable", 32'(stableBad), 0);
        dcReq = 1'b0; dcDirty = 1'b0;
        @(negedge clk);

        // Reset while the third refill word is outstanding.
        memAck = 1'b1; icReq = 1'b1;
        repeat (3) @(negedge clk);
        #1 chk("pre-reset widx", 32'(fillWidx), 2);
        rst = 1'b1;
        #1 chkAllZero("async reset");
        icReq = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0; icReq = 1'b1;
        doneCnt = 0; doneAt = -1; firstFillWidx = -1; firstFillAddr = '0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (cyc > 0) @(negedge clk);
            #1;
            if (memReq && firstFillWidx < 0) begin
                firstFillWidx = int'(fillWidx);
                firstFillAddr = memAddr;
            end
            if (icDone || dcDone) begin
                doneCnt++;
                if (doneAt < 0) doneAt = cyc;
                icReq = 1'b0;
            end
        end
        chk("restart widx", 32'(firstFillWidx), 0);
        chk("restart addr", firstFillAddr, 32'h1230);
        chk("restart done count", 32'(doneCnt), 1);
        chk("restart done cycle", 32'(doneAt), 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion before 200000");
        $fatal(1);
    end

endmodule
